uart_tx_fifo: RTL and testbench

- UART transmitter that generates the serial stream consumed by the team's UART receiver (8N1, LSB first, line idle high).
- Accepts bytes over a valid/ready handshake into a small FIFO.
- Serializes FIFO bytes back-to-back at a programmable baud, and pulses a done strobe per completed frame.
- Sits between the on-chip byte producer and the TX pad.

---
 rtl/uart_tx_fifo.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter (LSB first, idle high) fed by a small byte FIFO over a valid/ready handshake.
// Frames are sent back-to-back at BAUD_RATE_CNT clocks per bit, with a done pulse at the end of each stop bit.
module uart_tx_fifo #(
    parameter int BAUD_RATE_CNT = 5208,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_tx_valid,
    input  logic [7:0] in_tx_byte,
    output logic       out_tx_ready,
    output logic       data_serial,
    output logic       out_tx_busy,
    output logic       out_tx_done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0]   BAUD_LAST = 16'(BAUD_RATE_CNT - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    state_t        r_state;
    logic [15:0]   r_baud;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_serial;
    logic          r_done;

    state_t        w_state_nxt;
    logic [15:0]   w_baud_nxt;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    w_shift_nxt;
    logic          w_serial_nxt;
    logic          w_done_nxt;
    logic          w_pop;
    logic          w_push;
    logic          w_not_empty;
    logic          w_baud_last;
    logic [7:0]    w_head;

    assign out_tx_ready = (r_count < DEPTH_C);
    assign out_tx_busy  = (r_state != S_IDLE) || (r_count != {CW{1'b0}});
    assign data_serial  = r_serial;
    assign out_tx_done  = r_done;

    assign w_push      = in_tx_valid && out_tx_ready;
    assign w_not_empty = (r_count != {CW{1'b0}});
    assign w_baud_last = (r_baud == BAUD_LAST);
    assign w_head      = r_mem[r_rd_ptr];

    // FIFO storage: data only, validity is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wr_ptr] <= in_tx_byte;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Framing FSM next-state: the line value is decided one edge ahead so data_serial stays registered
    always_comb begin
        w_state_nxt  = r_state;
        w_baud_nxt   = r_baud;
        w_bit_nxt    = r_bit_idx;
        w_shift_nxt  = r_shift;
        w_serial_nxt = r_serial;
        w_done_nxt   = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_serial_nxt = 1'b1;
                if (w_not_empty) begin
                    w_pop        = 1'b1;
                    w_shift_nxt  = w_head;
                    w_baud_nxt   = 16'd0;
                    w_serial_nxt = 1'b0;
                    w_state_nxt  = S_START;
                end else begin
                    w_state_nxt  = S_IDLE;
                end
            end
            S_START: begin
                if (w_baud_last) begin
                    w_baud_nxt   = 16'd0;
                    w_bit_nxt    = 3'd0;
                    w_serial_nxt = r_shift[0];
                    w_state_nxt  = S_DATA;
                end else begin
                    w_baud_nxt   = r_baud + 16'd1;
                end
            end
            S_DATA: begin
                if (w_baud_last) begin
                    w_baud_nxt = 16'd0;
                    if (r_bit_idx == 3'd7) begin
                        w_serial_nxt = 1'b1;
                        w_state_nxt  = S_STOP;
                    end else begin
                        w_bit_nxt    = r_bit_idx + 3'd1;
                        w_shift_nxt  = {1'b0, r_shift[7:1]};
                        w_serial_nxt = r_shift[1];
                    end
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            S_STOP: begin
                if (w_baud_last) begin
                    w_done_nxt = 1'b1;
                    w_baud_nxt = 16'd0;
                    if (w_not_empty) begin
                        w_pop        = 1'b1;
                        w_shift_nxt  = w_head;
                        w_serial_nxt = 1'b0;
                        w_state_nxt  = S_START;
                    end else begin
                        w_serial_nxt = 1'b1;
                        w_state_nxt  = S_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_serial_nxt = 1'b1;
                w_baud_nxt   = 16'd0;
                w_bit_nxt    = 3'd0;
            end
        endcase
    end

    // Framing FSM registers; reset abandons any partial frame without a done pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_baud    <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_serial  <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit_idx <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_serial  <= w_serial_nxt;
            r_done    <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus random traffic, all compared every
// cycle against a frame-timeline reference model (queue of bytes + position inside the current frame).
module tb_uart_tx_fifo;

    localparam int N = 8;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_tx_valid;
    logic [7:0] in_tx_byte;
    logic       out_tx_ready;
    logic       data_serial;
    logic       out_tx_busy;
    logic       out_tx_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.BAUD_RATE_CNT(N), .FIFO_DEPTH(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_tx_valid  (in_tx_valid),
        .in_tx_byte   (in_tx_byte),
        .out_tx_ready (out_tx_ready),
        .data_serial  (data_serial),
        .out_tx_busy  (out_tx_busy),
        .out_tx_done  (out_tx_done)
    );

    always @(posedge clk) cyc++;

    // Reference model: a frame is 10 slots of N cycles (start, 8 data LSB first, stop)
    logic [7:0] q[$];
    bit         m_act  = 1'b0;
    bit         m_acc  = 1'b0;
    int         m_tpos = 0;
    logic [7:0] m_cur  = 8'h00;
    logic       m_line  = 1'b1;
    logic       m_done  = 1'b0;
    logic       m_busy  = 1'b0;
    logic       m_ready = 1'b1;

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        else if (k == 9) return 1'b1;
        else return b[k-1];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_act  = 1'b0;
            m_tpos = 0;
            m_done = 1'b0;
        end else begin
            m_acc  = in_tx_valid && (q.size() < D);
            m_done = 1'b0;
            if (m_act) begin
                m_tpos++;
                if (m_tpos == 10 * N) begin
                    m_act  = 1'b0;
                    m_done = 1'b1;
                end
            end
            if (!m_act && q.size() != 0) begin
                m_cur  = q.pop_front();
                m_act  = 1'b1;
                m_tpos = 0;
            end
            if (m_acc) q.push_back(in_tx_byte);
        end
        m_line  = m_act ? frame_bit(m_cur, m_tpos / N) : 1'b1;
        m_busy  = m_act || (q.size() != 0);
        m_ready = (q.size() < D);
    end

    task automatic test_reset();
        rst_n = 1'b0; in_tx_valid = 1'b0; in_tx_byte = 8'h00;
        repeat (3) @(negedge clk);
        total++;
        if ({data_serial, out_tx_done, out_tx_busy, out_tx_ready} !== 4'b1001) begin
            bad++;
            $display("FAIL reset_state got(line,done,busy,ready)=%b%b%b%b want=1001",
                     data_serial, out_tx_done, out_tx_busy, out_tx_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int acc_e, fall_e, done_e, nd;
        logic [9:0] seq;
        seq = 10'b1101001010;
        fall_e = -1; done_e = -1; nd = 0;
        @(negedge clk); in_tx_valid = 1'b1; in_tx_byte = 8'hA5;
        @(negedge clk); acc_e = cyc; in_tx_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            total++;
            if ({data_serial, out_tx_done, out_tx_busy, out_tx_ready} !== {m_line, m_done, m_busy, m_ready}) begin
                bad++;
                $display("FAIL single_model cyc=%0d got=%b want=%b", cyc,
                         {data_serial, out_tx_done, out_tx_busy, out_tx_ready}, {m_line, m_done, m_busy, m_ready});
            end
            if (fall_e < 0 && data_serial === 1'b0) fall_e = cyc;
            if (fall_e >= 0 && cyc - fall_e < 10 * N) begin
                total++;
                if (data_serial !== seq[(cyc - fall_e) / N]) begin
                    bad++;
                    $display("FAIL single_seq offset=%0d got=%b want=%b", cyc - fall_e, data_serial, seq[(cyc - fall_e) / N]);
                end
            end
            if (out_tx_done === 1'b1) begin nd++; done_e = cyc; end
            if (done_e >= 0 && cyc == done_e + 1) begin
                total++;
                if (out_tx_busy !== 1'b0) begin
                    bad++;
                    $display("FAIL single_busy_after_done got=%b want=0", out_tx_busy);
                end
            end
        end
        total++;
        if (fall_e - acc_e != 1) begin bad++; $display("FAIL single_latency got=%0d want=1", fall_e - acc_e); end
        total++;
        if (done_e - fall_e != 10 * N) begin bad++; $display("FAIL single_done_time got=%0d want=%0d", done_e - fall_e, 10 * N); end
        total++;
        if (nd != 1) begin bad++; $display("FAIL single_done_count got=%0d want=1", nd); end
    endtask

    task automatic test_burst();
        int idx, nd;
        int acc_c[6];
        int done_c[8];
        bit pend;
        logic rdy5;
        idx = 0; nd = 0; rdy5 = 1'b1;
        for (int k = 0; k < 6; k++) acc_c[k] = -1000;
        for (int k = 0; k < 8; k++) done_c[k] = -1000;
        @(negedge clk); in_tx_valid = 1'b1; in_tx_byte = 8'h01; pend = out_tx_ready;
        for (int i = 0; i < 520; i++) begin
            @(negedge clk);
            total++;
            if ({data_serial, out_tx_done, out_tx_busy, out_tx_ready} !== {m_line, m_done, m_busy, m_ready}) begin
                bad++;
                $display("FAIL burst_model cyc=%0d got=%b want=%b", cyc,
                         {data_serial, out_tx_done, out_tx_busy, out_tx_ready}, {m_line, m_done, m_busy, m_ready});
            end
            if (out_tx_done === 1'b1 && nd < 8) begin done_c[nd] = cyc; nd++; end
            if (pend && idx < 6) begin
                acc_c[idx] = cyc; idx++;
                if (idx == 5) rdy5 = out_tx_ready;
            end
            in_tx_valid = (idx < 6);
            in_tx_byte  = 8'(idx + 1);
            pend = in_tx_valid && out_tx_ready;
        end
        in_tx_valid = 1'b0;
        total++;
        if (idx != 6) begin bad++; $display("FAIL burst_accepts got=%0d want=6", idx); end
        total++;
        if (acc_c[4] - acc_c[0] != 4) begin bad++; $display("FAIL burst_first5 got=%0d want=4", acc_c[4] - acc_c[0]); end
        total++;
        if (rdy5 !== 1'b0) begin bad++; $display("FAIL burst_full_ready got=%b want=0", rdy5); end
        total++;
        if (acc_c[5] != done_c[0] + 1) begin bad++; $display("FAIL burst_sixth_accept got=%0d want=%0d", acc_c[5], done_c[0] + 1); end
        total++;
        if (nd != 6) begin bad++; $display("FAIL burst_done_count got=%0d want=6", nd); end
        for (int k = 1; k < 6; k++) begin
            total++;
            if (done_c[k] - done_c[k-1] != 10 * N) begin
                bad++;
                $display("FAIL burst_done_spacing k=%0d got=%0d want=%0d", k, done_c[k] - done_c[k-1], 10 * N);
            end
        end
    endtask

    task automatic test_extremes();
        logic h[250];
        int f, nmis;
        logic exp_v;
        f = -1; nmis = 0;
        @(negedge clk); in_tx_valid = 1'b1; in_tx_byte = 8'h00;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            total++;
            if ({data_serial, out_tx_done, out_tx_busy, out_tx_ready} !== {m_line, m_done, m_busy, m_ready}) begin
                bad++;
                $display("FAIL extremes_model cyc=%0d got=%b want=%b", cyc,
                         {data_serial, out_tx_done, out_tx_busy, out_tx_ready}, {m_line, m_done, m_busy, m_ready});
            end
            h[i] = data_serial;
            if (f < 0 && data_serial === 1'b0) f = i;
            if (i == 0) in_tx_byte = 8'hFF;
            if (i == 1) in_tx_valid = 1'b0;
        end
        if (f < 0) begin
            nmis = 1;
        end else begin
            for (int j = f; j < 250; j++) begin
                exp_v = ((j - f) < 72) ? 1'b0 : ((j - f) < 80) ? 1'b1 : ((j - f) < 88) ? 1'b0 : 1'b1;
                if (h[j] !== exp_v) nmis++;
            end
        end
        total++;
        if (nmis != 0) begin bad++; $display("FAIL extremes_runs got=%0d mismatched cycles want=0 (fall at %0d)", nmis, f); end
        total++;
        if (out_tx_busy !== 1'b0) begin bad++; $display("FAIL extremes_idle_busy got=%b want=0", out_tx_busy); end
    endtask

    task automatic test_reset_mid();
        int f, nd, nact;
        f = -1; nd = 0; nact = 0;
        @(negedge clk); in_tx_valid = 1'b1; in_tx_byte = 8'h81;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            total++;
            if ({data_serial, out_tx_done, out_tx_busy, out_tx_ready} !== {m_line, m_done, m_busy, m_ready}) begin
                bad++;
                $display("FAIL resetmid_model cyc=%0d got=%b want=%b", cyc,
                         {data_serial, out_tx_done, out_tx_busy, out_tx_ready}, {m_line, m_done, m_busy, m_ready});
            end
            case (i)
                0:       in_tx_byte = 8'h42;
                1:       in_tx_byte = 8'h24;
                2:       in_tx_valid = 1'b0;
                default: ;
            endcase
            if (f < 0 && data_serial === 1'b0) f = cyc;
            if (f >= 0 && cyc > f + 36) begin
                if (out_tx_done === 1'b1) nd++;
                if (data_serial !== 1'b1 || out_tx_busy !== 1'b0) nact++;
            end
            if (f >= 0 && cyc == f + 36) begin
                total++;
                if ({data_serial, out_tx_done, out_tx_busy, out_tx_ready} !== 4'b1001) begin
                    bad++;
                    $display("FAIL resetmid_state got(line,done,busy,ready)=%b%b%b%b want=1001",
                             data_serial, out_tx_done, out_tx_busy, out_tx_ready);
                end
                rst_n = 1'b1;
            end
            if (f >= 0 && cyc == f + 35) rst_n = 1'b0;
        end
        total++;
        if (f < 0) begin bad++; $display("FAIL resetmid_no_frame got=none want=start bit"); end
        total++;
        if (nd != 0) begin bad++; $display("FAIL resetmid_done got=%0d want=0", nd); end
        total++;
        if (nact != 0) begin bad++; $display("FAIL resetmid_activity got=%0d cycles want=0", nact); end
    endtask

    task automatic test_valid_in_reset();
        int nact;
        nact = 0;
        @(negedge clk); rst_n = 1'b0; in_tx_valid = 1'b1; in_tx_byte = 8'h3C;
        @(negedge clk);
        total++;
        if ({data_serial, out_tx_busy, out_tx_ready} !== 3'b101) begin
            bad++;
            $display("FAIL vreset_state got(line,busy,ready)=%b%b%b want=101", data_serial, out_tx_busy, out_tx_ready);
        end
        @(negedge clk); rst_n = 1'b1; in_tx_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            total++;
            if ({data_serial, out_tx_done, out_tx_busy, out_tx_ready} !== {m_line, m_done, m_busy, m_ready}) begin
                bad++;
                $display("FAIL vreset_model cyc=%0d got=%b want=%b", cyc,
                         {data_serial, out_tx_done, out_tx_busy, out_tx_ready}, {m_line, m_done, m_busy, m_ready});
            end
            if (data_serial !== 1'b1 || out_tx_busy !== 1'b0) nact++;
        end
        total++;
        if (nact != 0) begin bad++; $display("FAIL vreset_activity got=%0d cycles want=0", nact); end
    endtask

    task automatic test_push_midframe();
        int nd;
        int done_c[4];
        nd = 0;
        for (int k = 0; k < 4; k++) done_c[k] = -1000;
        @(negedge clk); in_tx_valid = 1'b1; in_tx_byte = 8'h11;
        @(negedge clk); in_tx_valid = 1'b0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            total++;
            if ({data_serial, out_tx_done, out_tx_busy, out_tx_ready} !== {m_line, m_done, m_busy, m_ready}) begin
                bad++;
                $display("FAIL midpush_model cyc=%0d got=%b want=%b", cyc,
                         {data_serial, out_tx_done, out_tx_busy, out_tx_ready}, {m_line, m_done, m_busy, m_ready});
            end
            if (out_tx_done === 1'b1 && nd < 4) begin done_c[nd] = cyc; nd++; end
            if (i == 30) begin
                total++;
                if (out_tx_ready !== 1'b1) begin bad++; $display("FAIL midpush_ready got=%b want=1", out_tx_ready); end
                in_tx_valid = 1'b1; in_tx_byte = 8'h55;
            end
            if (i == 31) begin
                in_tx_valid = 1'b0;
                total++;
                if ({out_tx_busy, out_tx_ready} !== 2'b11) begin
                    bad++;
                    $display("FAIL midpush_queued got(busy,ready)=%b%b want=11", out_tx_busy, out_tx_ready);
                end
            end
        end
        total++;
        if (nd != 2) begin bad++; $display("FAIL midpush_done_count got=%0d want=2", nd); end
        total++;
        if (done_c[1] - done_c[0] != 10 * N) begin
            bad++;
            $display("FAIL midpush_back_to_back got=%0d want=%0d", done_c[1] - done_c[0], 10 * N);
        end
    endtask

    task automatic test_random();
        bit pend;
        int rate;
        pend = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            total++;
            if ({data_serial, out_tx_done, out_tx_busy, out_tx_ready} !== {m_line, m_done, m_busy, m_ready}) begin
                bad++;
                $display("FAIL random_model cyc=%0d got=%b want=%b", cyc,
                         {data_serial, out_tx_done, out_tx_busy, out_tx_ready}, {m_line, m_done, m_busy, m_ready});
            end
            if (rst_n == 1'b0) rst_n = 1'b1;
            else if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
            rate = (i < 1200) ? 2 : 60;
            if (i >= 2100) begin
                in_tx_valid = 1'b0;
            end else if (!(in_tx_valid && !pend)) begin
                in_tx_valid = ($urandom_range(0, rate - 1) == 0);
                in_tx_byte  = 8'($urandom_range(0, 255));
            end
            pend = in_tx_valid && out_tx_ready && rst_n;
        end
        total++;
        if (out_tx_busy !== 1'b0) begin bad++; $display("FAIL random_drain_busy got=%b want=0", out_tx_busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_extremes();
        test_reset_mid();
        test_valid_in_reset();
        test_push_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
